// File: rtl/n1_sbus_ram.sv
// n1_sbus_ram: Wishbone pipelined stack-bus RAM target with wait states, range/tag checking and abort handling.
module n1_sbus_ram #(
  parameter int SP_WIDTH    = 12,
  parameter int MEM_DEPTH   = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic                clk_i,
  input  logic                sync_rst_i,
  input  logic                sbus_cyc_i,
  input  logic                sbus_stb_i,
  input  logic                sbus_we_i,
  input  logic [SP_WIDTH-1:0] sbus_adr_i,
  input  logic [15:0]         sbus_dat_i,
  input  logic                sbus_tga_ps_i,
  input  logic                sbus_tga_rs_i,
  output logic                sbus_ack_o,
  output logic                sbus_err_o,
  output logic                sbus_rty_o,
  output logic                sbus_stall_o,
  output logic [15:0]         sbus_dat_o
);
  localparam int AW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t        state_q;
  logic [2:0]    cnt_q;
  logic          ack_q, err_q, stall_q, buf_err_q;
  logic [15:0]   dat_q, buf_q;
  logic [15:0]   mem [MEM_DEPTH];
  logic          acc, legal;
  logic [AW-1:0] idx;
  logic [15:0]   rd;
  assign acc   = sbus_cyc_i & sbus_stb_i & ~stall_q;
  assign legal = (32'(sbus_adr_i) < MEM_DEPTH) & (sbus_tga_ps_i ^ sbus_tga_rs_i);
  assign idx   = sbus_adr_i[AW-1:0];
  assign rd    = (legal & ~sbus_we_i) ? mem[idx] : 16'h0000;
  always_ff @(posedge clk_i) begin
    if (acc & legal & sbus_we_i) mem[idx] <= sbus_dat_i;
  end
  // Response payload is captured at acceptance and parked in buf_q while waiting.
  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      stall_q   <= 1'b0;
      dat_q     <= 16'h0000;
      buf_q     <= 16'h0000;
      buf_err_q <= 1'b0;
    end else begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= 1'b0;
      dat_q   <= 16'h0000;
      if (!sbus_cyc_i) begin
        state_q <= IDLE;
        cnt_q   <= 3'd0;
      end else if (acc) begin
        if (WAIT_STATES == 0) begin
          state_q <= RESP;
          ack_q   <= legal;
          err_q   <= ~legal;
          dat_q   <= rd;
        end else begin
          state_q   <= WAIT;
          cnt_q     <= 3'(WAIT_STATES);
          stall_q   <= 1'b1;
          buf_q     <= rd;
          buf_err_q <= ~legal;
        end
      end else if (state_q == WAIT) begin
        if (cnt_q == 3'd1) begin
          state_q <= RESP;
          cnt_q   <= 3'd0;
          ack_q   <= ~buf_err_q;
          err_q   <= buf_err_q;
          dat_q   <= buf_q;
        end else begin
          cnt_q   <= cnt_q - 3'd1;
          stall_q <= 1'b1;
        end
      end else begin
        state_q <= IDLE;
      end
    end
  end
  assign sbus_ack_o   = ack_q;
  assign sbus_err_o   = err_q;
  assign sbus_rty_o   = 1'b0;
  assign sbus_stall_o = stall_q;
  assign sbus_dat_o   = dat_q;
endmodule

// File: doc/n1_sbus_ram.md
Name: n1_sbus_ram

Overview:
- Wishbone pipelined target for the N1 stack bus (sbus); it backs both the parameter stack and the return stack in one word-addressed RAM.
- Sits directly downstream of the N1 core's sbus initiator port.
- Serves the lower-stack spill/fill traffic that the intermediate stacks generate.
- Provides configurable wait states, address range checking and cycle-abort handling, so the core's stall, ack and err paths can be exercised.

Parameters:
SP_WIDTH, 12, width of sbus address (stack pointer width)
MEM_DEPTH, 4096, number of 16-bit words implemented (1..2**SP_WIDTH)
WAIT_STATES, 0, extra cycles per access (0..7); response latency = WAIT_STATES+1

Ports:
clk_i  in  1  module clock
sync_rst_i  in  1  synchronous reset, active high
sbus_cyc_i  in  1  bus cycle indicator
sbus_stb_i  in  1  access request
sbus_we_i  in  1  write enable
sbus_adr_i  in  SP_WIDTH  word address
sbus_dat_i  in  16  write data
sbus_tga_ps_i  in  1  parameter stack access tag
sbus_tga_rs_i  in  1  return stack access tag
sbus_ack_o  out  1  bus cycle acknowledge
sbus_err_o  out  1  error indicator
sbus_rty_o  out  1  retry request (reserved, constant 0)
sbus_stall_o  out  1  access delay
sbus_dat_o  out  16  read data

Behaviour:
- Single clock domain clk_i. Reset is synchronous and active-high on sync_rst_i; there is no asynchronous reset.
- Reset values: ack_o=0, err_o=0, rty_o=0, stall_o=0, dat_o=16'h0000, wait counter=0, FSM=IDLE. RAM contents are not reset.
- Acceptance: a request is accepted in a cycle where cyc_i & stb_i & !stall_o.
- Legality: a request is legal if adr_i < MEM_DEPTH and exactly one of tga_ps_i / tga_rs_i is set. Otherwise it is illegal.
- Writes: a legal write commits to RAM at the clock edge ending the acceptance cycle. An illegal write never modifies RAM.
- Reads: a legal read samples RAM after any write committed in an earlier cycle (read-after-write returns the new value).
- Response: exactly one of ack_o/err_o pulses for one cycle, WAIT_STATES+1 cycles after acceptance.
  - Legal access: ack_o. dat_o = read data for reads, 16'h0000 for writes.
  - Illegal access: err_o, dat_o=0.
  - dat_o is 0 in every cycle without ack_o.
- FSM states:
  - IDLE: stall_o=0, no pending response. Acceptance with WAIT_STATES=0 -> RESP. Acceptance with WAIT_STATES>0 -> WAIT, counter=WAIT_STATES.
  - WAIT: stall_o=1, counter decrements each cycle. Counter reaching 1 -> RESP.
  - RESP: ack_o/err_o asserted, stall_o=0. A new acceptance in the same cycle is allowed (back-to-back): go to RESP or WAIT as from IDLE. Otherwise -> IDLE.
- Throughput: with WAIT_STATES=0, one access per cycle; stall_o is never asserted. With WAIT_STATES=k, one access per k+1 cycles.
- Abort: cyc_i=0 in any cycle cancels the pending response.
  - No ack/err is issued in the next cycle.
  - FSM -> IDLE and counter=0; stall_o=0 from the next cycle.
  - A write already accepted stays committed.
- stb_i while cyc_i=0 is ignored.
- sync_rst_i mid-access: the pending response is dropped, all outputs take reset values next cycle, and a committed write is kept.
- Address checking uses the full SP_WIDTH bits. When MEM_DEPTH=2**SP_WIDTH, no address errors can occur.

Test Plan:
- WAIT_STATES=0: write 16'hA5A5 to adr 12'h010 (tga_ps) in cycle 0, read adr 12'h010 in cycle 1 -> ack_o in cycles 1 and 2, dat_o=16'hA5A5 in cycle 2, stall_o never 1.
- WAIT_STATES=2: read accepted in cycle 0 -> stall_o=1 in cycles 1–2, ack_o in cycle 3. A second stb held high from cycle 1 is accepted in cycle 3, with ack in cycle 6.
- MEM_DEPTH=2048: write 16'h1234 to adr 12'h800 -> err_o one cycle later, no ack_o. A read of adr 12'h000 still returns its prior value. tga_ps_i=tga_rs_i=1 on a legal address -> err_o.
- WAIT_STATES=3: write 16'hBEEF to adr 12'h020, drop cyc_i in cycle 2 -> no ack/err ever, stall_o=0 from cycle 3. A later read of 12'h020 returns 16'hBEEF.
- sync_rst_i asserted in the WAIT state -> next cycle ack_o=err_o=stall_o=0 and dat_o=0. The first request after reset completes with the normal latency.
